// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the load/store
// unit (requester 0) and the loader/DMA path (requester 1).
module data_memory_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int WDATA_W = 16,
    parameter int RDATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata0,
    input  logic [WDATA_W-1:0] wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [RDATA_W-1:0] rdata0,
    output logic [RDATA_W-1:0] rdata1,
    output logic               busy,
    output logic               mem_write_en,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_data_in,
    input  logic [RDATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;     // requester that wins a tie
    logic               winner_q, winner_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [RDATA_W-1:0] rdata0_q, rdata0_d;
    logic [RDATA_W-1:0] rdata1_q, rdata1_d;

    logic pick;
    assign pick = req1 && (!req0 || prio_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        prio_d    = prio_q;
        winner_d  = winner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d = pick;
                    prio_d   = ~pick;
                    we_d     = pick ? we1 : we0;
                    addr_d   = pick ? addr1 : addr0;
                    wdata_d  = pick ? wdata1 : wdata0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                if (winner_q) begin
                    rdata1_d  = mem_data_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_data_out;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            winner_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            winner_q  <= winner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Grants and the write strobe are decoded from registered state only.
    assign gnt0         = (state_q == ACCESS) && !winner_q;
    assign gnt1         = (state_q == ACCESS) &&  winner_q;
    assign mem_write_en = (state_q == ACCESS) &&  we_q;
    assign busy         = (state_q != IDLE);
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed vectors, hand-written
// corner sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_write_en;
    logic [7:0]  rdata0, rdata1, mem_data_out;
    logic [15:0] mem_addr, mem_data_in;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_arbiter #(.ADDR_W(16), .WDATA_W(16), .RDATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Single-port data memory: synchronous byte write, registered read.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_data_in[7:0];
        mem_data_out <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r0;
        logic        we0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic        r1;
        logic        we1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic [1:0]  exp_gnt;   // {gnt1, gnt0}
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic       w;
        logic [7:0] data;
        int         due;
    } rd_t;

    vec_t vecs [12];
    logic [7:0] exp_rd [2];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Transactions from IDLE; tie winners follow the round-robin history.
        vecs[0]  = '{1'b1, 1'b1, 16'd2,  16'd25,     1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b1, 16'd2,  16'd25,     8'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'd5,  16'd50,     1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b1, 16'd5,  16'd50,     8'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'd10, 16'd250,    1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b1, 16'd10, 16'd250,    8'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'd2,  16'd0,      1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b0, 16'd2,  16'd0,      8'd25};
        vecs[4]  = '{1'b1, 1'b0, 16'd5,  16'd0,      1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b0, 16'd5,  16'd0,      8'd50};
        vecs[5]  = '{1'b1, 1'b0, 16'd10, 16'd0,      1'b0, 1'b0, 16'd0, 16'd0,      2'b01, 1'b0, 16'd10, 16'd0,      8'd250};
        vecs[6]  = '{1'b0, 1'b0, 16'd0,  16'd0,      1'b1, 1'b0, 16'd10, 16'd0,     2'b10, 1'b0, 16'd10, 16'd0,      8'd250};
        vecs[7]  = '{1'b1, 1'b1, 16'd7,  16'h0311,   1'b1, 1'b1, 16'd8, 16'h0499,   2'b01, 1'b1, 16'd7,  16'h0311,   8'd0};
        vecs[8]  = '{1'b0, 1'b0, 16'd0,  16'd0,      1'b1, 1'b1, 16'd8, 16'h0422,   2'b10, 1'b1, 16'd8,  16'h0422,   8'd0};
        vecs[9]  = '{1'b1, 1'b0, 16'd7,  16'd0,      1'b1, 1'b0, 16'd8, 16'd0,      2'b01, 1'b0, 16'd7,  16'd0,      8'h11};
        vecs[10] = '{1'b1, 1'b0, 16'd7,  16'd0,      1'b1, 1'b0, 16'd8, 16'd0,      2'b10, 1'b0, 16'd8,  16'd0,      8'h22};
        vecs[11] = '{1'b1, 1'b1, 16'd2,  16'h0019,   1'b1, 1'b1, 16'd9, 16'd5,      2'b01, 1'b1, 16'd2,  16'h0019,   8'd0};

        // Reset and idle.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_we", mem_write_en, 0);
            check("idle_gnt", {gnt1, gnt0}, 0);
            check("idle_rvalid", {rvalid1, rvalid0}, 0);
            check("idle_addr", mem_addr, 0);
        end
        check("idle_rdata", {rdata1, rdata0}, 0);
        exp_rd[0] = 8'd0;
        exp_rd[1] = 8'd0;

        // Directed vectors.
        foreach (vecs[i]) begin
            req0 = vecs[i].r0; we0 = vecs[i].we0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
            req1 = vecs[i].r1; we1 = vecs[i].we1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
            step();
            check($sformatf("vec%0d_gnt", i), {gnt1, gnt0}, vecs[i].exp_gnt);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_we", i), mem_write_en, vecs[i].exp_we);
            check($sformatf("vec%0d_busy", i), busy, 1);
            if (vecs[i].exp_we) check($sformatf("vec%0d_wdata", i), mem_data_in, vecs[i].exp_wdata);
            req0 = 1'b0;
            req1 = 1'b0;
            step();
            check($sformatf("vec%0d_we_after", i), mem_write_en, 0);
            if (!vecs[i].exp_we) begin
                check($sformatf("vec%0d_addr_held", i), mem_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_rvalid_early", i), {rvalid1, rvalid0}, 0);
                step();
                exp_rd[vecs[i].exp_gnt[1]] = vecs[i].exp_rdata;
                check($sformatf("vec%0d_rvalid", i), {rvalid1, rvalid0}, vecs[i].exp_gnt);
                check($sformatf("vec%0d_rdata0", i), rdata0, exp_rd[0]);
                check($sformatf("vec%0d_rdata1", i), rdata1, exp_rd[1]);
            end else begin
                check($sformatf("vec%0d_idle", i), busy, 0);
            end
        end

        // Both requesters writing continuously from reset: grants alternate.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd1; wdata0 = 16'h00A1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd3; wdata1 = 16'h00B3;
        for (int k = 0; k < 8; k++) begin
            step();
            check("alt_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_addr", mem_addr, (k % 2 == 0) ? 16'd1 : 16'd3);
            check("alt_we", mem_write_en, 1);
            step();
            check("alt_gap", {gnt1, gnt0}, 0);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // req1 arrives during req0's read access and waits for the next IDLE.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10;
        step();
        check("ovl_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
        step();
        check("ovl_rdata_cycle", {gnt1, gnt0}, 0);
        check("ovl_rdata_busy", busy, 1);
        step();
        check("ovl_idle_gnt", {gnt1, gnt0}, 0);
        check("ovl_rvalid0", {rvalid1, rvalid0}, 2'b01);
        check("ovl_rdata0", rdata0, 250);
        step();
        check("ovl_gnt1", {gnt1, gnt0}, 2'b10);
        check("ovl_addr1", mem_addr, 2);
        check("ovl_we1", mem_write_en, 0);
        req1 = 1'b0;
        step();
        step();
        check("ovl_rvalid1", {rvalid1, rvalid0}, 2'b10);
        check("ovl_rdata1", rdata1, 25);

        // Reset in the RDATA cycle suppresses the pending rvalid.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd5;
        step();
        check("rst_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_rvalid", {rvalid1, rvalid0}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10;
        step();
        check("rst_regrant", {gnt1, gnt0}, 2'b01);
        check("rst_regrant_addr", mem_addr, 10);
        req0 = 1'b0;
        step();
        step();
        check("rst_rvalid_after", {rvalid1, rvalid0}, 2'b01);
        check("rst_rdata_after", rdata0, 250);

        run_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Randomized traffic on fresh addresses 32..47, scored at transaction level.
    task automatic run_random();
        logic        cur_req [2];
        logic        cur_we [2];
        logic [15:0] cur_addr [2];
        logic [15:0] cur_wdata [2];
        int          wait_cnt [2];
        logic [7:0]  ref_mem [16];
        logic [7:0]  ref_rd [2];
        rd_t         rq [$];
        logic        last_gnt;
        logic        abort;
        localparam int N = 3000;

        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        for (int r = 0; r < 2; r++) begin
            cur_req[r] = 1'b0; cur_we[r] = 1'b0; cur_addr[r] = '0; cur_wdata[r] = '0;
            wait_cnt[r] = 0; ref_rd[r] = 8'd0;
        end
        last_gnt = 1'b1;
        abort    = 1'b0;

        for (int c = 0; c < N && !abort; c++) begin
            logic [1:0] g, exp_g, exp_rv;
            logic       exp_we_now;
            logic       w;
            step();
            g          = {gnt1, gnt0};
            exp_we_now = 1'b0;
            w          = gnt1;
            if (g != 2'b00) begin
                if (cur_req[0] && cur_req[1]) exp_g = last_gnt ? 2'b01 : 2'b10;
                else if (cur_req[0])          exp_g = 2'b01;
                else if (cur_req[1])          exp_g = 2'b10;
                else                          exp_g = 2'b00;
                check("rand_gnt", g, exp_g);
                check("rand_addr", mem_addr, cur_addr[w]);
                exp_we_now = cur_we[w];
                if (cur_we[w]) begin
                    check("rand_wdata", mem_data_in, cur_wdata[w]);
                    ref_mem[cur_addr[w][3:0]] = cur_wdata[w][7:0];
                end else begin
                    rq.push_back('{w, ref_mem[cur_addr[w][3:0]], c + 2});
                end
                last_gnt = w;
            end
            check("rand_we", mem_write_en, exp_we_now);

            exp_rv = 2'b00;
            if (rq.size() > 0 && rq[0].due == c) begin
                exp_rv = rq[0].w ? 2'b10 : 2'b01;
                ref_rd[rq[0].w] = rq[0].data;
                void'(rq.pop_front());
            end
            check("rand_rvalid", {rvalid1, rvalid0}, exp_rv);
            check("rand_rdata0", rdata0, ref_rd[0]);
            check("rand_rdata1", rdata1, ref_rd[1]);

            for (int r = 0; r < 2; r++) begin
                logic granted;
                granted = (g != 2'b00) && (w == r[0]);
                if (granted || !cur_req[r]) begin
                    wait_cnt[r] = 0;
                    cur_req[r]  = 1'b0;
                    if (c < N - 10 && $urandom_range(0, 2) != 0) begin
                        cur_req[r]   = 1'b1;
                        cur_we[r]    = 1'($urandom_range(0, 1));
                        cur_addr[r]  = 16'd32 + 16'($urandom_range(0, 15));
                        cur_wdata[r] = 16'($urandom);
                    end
                end else begin
                    wait_cnt[r]++;
                    if (wait_cnt[r] > 12) begin
                        check("rand_timeout", wait_cnt[r], 12);
                        abort = 1'b1;
                    end
                end
            end
            req0 = cur_req[0]; we0 = cur_we[0]; addr0 = cur_addr[0]; wdata0 = cur_wdata[0];
            req1 = cur_req[1]; we1 = cur_we[1]; addr1 = cur_addr[1]; wdata1 = cur_wdata[1];
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rand_drain", rq.size(), 0);
    endtask

endmodule
